// File: rtl/ff_toggle_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : ff_toggle_arbiter
// Purpose  : Four requesters share one W-bit T-flip-flop register. Each command
//            (D/T/SR/JK) is granted round-robin and applied as a toggle vector.
// Revision : 1.0 - initial release
//==============================================================================
module ff_toggle_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [7:0]     mode,
    input  logic [4*W-1:0] a,
    input  logic [4*W-1:0] b,
    output logic [3:0]     ack,
    output logic [W-1:0]   q,
    output logic [W-1:0]   qb,
    output logic           busy,
    output logic           err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;

    logic [1:0]   state_q, state_d;
    logic [1:0]   last_grant_q;
    logic [1:0]   grant_q;
    logic [1:0]   cmd_mode_q;
    logic [W-1:0] op_a_q;
    logic [W-1:0] op_b_q;
    logic [W-1:0] reg_q;
    logic [3:0]   ack_q;
    logic         err_q;

    logic         gnt_found_w;
    logic [1:0]   gnt_idx_w;
    logic [1:0]   cand_w;
    logic [W-1:0] toggle_w;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        gnt_found_w = 1'b0;
        gnt_idx_w   = last_grant_q;
        cand_w      = last_grant_q;
        for (int k = 0; k < 4; k++) begin
            cand_w = last_grant_q + 2'(k + 1);
            if (!gnt_found_w && req[cand_w]) begin
                gnt_found_w = 1'b1;
                gnt_idx_w   = cand_w;
            end
        end
    end

    always_comb begin
        toggle_w = '0;
        case (cmd_mode_q)
            MODE_D:  toggle_w = op_a_q ^ reg_q;
            MODE_T:  toggle_w = op_a_q;
            MODE_SR: toggle_w = ((op_a_q & ~reg_q) | (op_b_q & reg_q)) & ~(op_a_q & op_b_q);
            MODE_JK: toggle_w = (op_a_q & ~reg_q) | (op_b_q & reg_q);
            default: toggle_w = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_found_w) state_d = S_APPLY;
            S_APPLY: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 2'd3;
            grant_q      <= 2'd0;
            cmd_mode_q   <= MODE_D;
            op_a_q       <= '0;
            op_b_q       <= '0;
            reg_q        <= '0;
            ack_q        <= 4'b0000;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= 4'b0000;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_found_w) begin
                        grant_q    <= gnt_idx_w;
                        cmd_mode_q <= mode[2*int'(gnt_idx_w) +: 2];
                        op_a_q     <= a[W*int'(gnt_idx_w) +: W];
                        op_b_q     <= b[W*int'(gnt_idx_w) +: W];
                    end
                end
                S_APPLY: begin
                    reg_q        <= reg_q ^ toggle_w;
                    last_grant_q <= grant_q;
                    ack_q        <= 4'b0001 << grant_q;
                    err_q        <= (cmd_mode_q == MODE_SR) && (|(op_a_q & op_b_q));
                end
                default: ;
            endcase
        end
    end

    assign ack  = ack_q;
    assign q    = reg_q;
    assign qb   = ~reg_q;
    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule
`default_nettype wire

// File: doc/ff_toggle_arbiter.md
FF_TOGGLE_ARBITER -- requirements
Module: ff_toggle_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, width of the shared T-flip-flop register.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 SHALL have port mode  input  8  2-bit command per requester, at [2i+1:2i]: 00 D, 01 T, 10 SR, 11 JK.
REQ-006 SHALL have port a  input  4*W  first operand per requester, at [W*i+W-1:W*i] (d, t, s or j).
REQ-007 SHALL have port b  input  4*W  second operand per requester, same slicing (r or k; ignored for D/T).
REQ-008 SHALL have port ack  output  4  one-hot completion pulse to the granted requester.
REQ-009 SHALL have port q  output  W  shared register state; qb  output  W  always ~q.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port err  output  1  SR conflict flag for the completing command.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, APPLY, ACK.
REQ-013 IDLE: if any req bit is high, SHALL grant one requester round-robin, starting the search at last_grant+1 (mod 4), and go to APPLY; otherwise stay in IDLE.
REQ-014 On the IDLE->APPLY edge, SHALL latch the grant index plus that requester's mode, a and b; later input changes SHALL NOT affect the command.
REQ-015 SHALL compute toggle vector t from the latched command and current q:
- D: t = a ^ q.
- T: t = a.
- SR: t = (a & ~q) | (b & q), with t forced to 0 on bits where a & b.
- JK: t = (a & ~q) | (b & q).
REQ-016 APPLY: SHALL update q <= q ^ t, update last_grant to the grant index, and go to ACK.
REQ-017 ACK: SHALL drive ack[grant] high for exactly one cycle, with all other ack bits low, then go to IDLE.
REQ-018 err SHALL be registered and high only during ACK, and only when the latched mode is SR and (a & b) != 0.
REQ-019 Latency: req first sampled high in IDLE at edge n -> new q visible after edge n+1 -> ack high in the cycle after edge n+1 -> IDLE after edge n+2.
REQ-020 A requester holding req high through its ack SHALL be treated as a new request; round-robin SHALL then grant any other pending requester first.
REQ-021 A req bit deasserted before grant SHALL be dropped without ack; req bits SHALL be ignored outside IDLE.
REQ-022 With a single requester, the grant SHALL go to that requester regardless of pointer.

Reset
REQ-023 When rst is high at a clock edge, SHALL set q=0, ack=0, err=0, state=IDLE, and last_grant=3, so requester 0 has first priority.
REQ-024 rst SHALL override any in-flight command in APPLY or ACK: the command is abandoned and no ack is issued; busy SHALL be 0 in the cycle after the rst edge.

Verification (W=8)
REQ-025 After reset, req=0001, mode0=D, a0=8'hA5 -> ack=0001 two cycles after first sample, q=8'hA5, qb=8'h5A, err=0.
REQ-026 After reset, req=1111 held, each requester deasserting after its ack -> acks in order 0001, 0010, 0100, 1000, one command per 3 cycles.
REQ-027 q=8'h0F, SR with s=8'hF0, r=8'h3C -> q=8'hC3 and err=1 during ACK.
REQ-028 q=8'hC3, JK with j=k=8'hFF -> q=8'h3C and err=0; then T with a=8'h00 -> q stays 8'h3C with ack issued.
REQ-029 rst asserted during APPLY of a D a=8'hFF command -> q=8'h00, ack never pulses, busy=0 next cycle.
REQ-030 Requester 2 holds req across its ack while requester 1 raises req -> requester 1 is granted next, then requester 2.
